// File: rtl/shift_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// shift_ctrl_pkg
// Shared definitions for the shift register sequencing controller:
//   - state_e   : controller FSM states (CLR, IDLE, LOAD, SHIFT, GAP)
//   - cnt_width : bit width needed to hold the values 0..max_val (minimum 1)
// -----------------------------------------------------------------------------
package shift_ctrl_pkg;

   typedef enum logic [2:0] {
      CLR   = 3'd0,
      IDLE  = 3'd1,
      LOAD  = 3'd2,
      SHIFT = 3'd3,
      GAP   = 3'd4
   } state_e;

   // Width of a counter that must represent 0..max_val inclusive.
   function automatic int cnt_width(input int max_val);
      int w;
      if (max_val < 32'sd1) begin
         w = 32'sd1;
      end else begin
         w = $clog2(max_val + 32'sd1);
      end
      return w;
   endfunction

endpackage

// File: rtl/shift_frame_cnt.sv
// -----------------------------------------------------------------------------
// shift_frame_cnt
// Loadable down-counter with terminal-count flag, shared by the SHIFT and GAP
// phases of the frame controller.
// Ports:
//   clock    : rising-edge clock
//   sclr     : synchronous active-high clear (count -> 0)
//   load     : load load_val this cycle (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one (saturates at zero)
//   last     : count is 1, i.e. the current cycle is the final one of a phase
// -----------------------------------------------------------------------------
module shift_frame_cnt #(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             sclr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic             last
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Next count: load wins over decrement; never wraps below zero.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec && (count_q != {WIDTH{1'b0}})) begin
         count_d = count_q - WIDTH'(1);
      end else begin
         count_d = count_q;
      end
   end

   // Count register with synchronous clear.
   always_ff @(posedge clock) begin
      if (sclr) begin
         count_q <= {WIDTH{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign last = (count_q == WIDTH'(1));

endmodule

// File: rtl/shift_frame_ctrl.sv
// -----------------------------------------------------------------------------
// shift_frame_ctrl
// Sequencing controller for an external parameterized shift register. Accepts
// a word over valid/ready, loads it, enables exactly SHIFT_WIDTH shifts while
// qualifying the serial output, then idles GAP_CYCLES cycles between frames.
// Ports:
//   clock, sclr        : clock and synchronous active-high reset
//   tx_valid/tx_data   : producer word; tx_ready high in IDLE only
//   abort              : cancel frame (honoured in LOAD/SHIFT only)
//   sr_sclr/sr_sset/sr_load/sr_enable/sr_shiftin/sr_data : shift reg controls
//   sr_shiftout        : shift register serial output
//   ser_out/ser_valid  : qualified serial bit stream
//   busy, done, aborted: status (done/aborted are one-cycle pulses)
//   bit_cnt            : shifts completed in current frame
// All outputs other than ser_out decode from registers only.
// -----------------------------------------------------------------------------
module shift_frame_ctrl
   import shift_ctrl_pkg::*;
#(
   parameter int   SHIFT_WIDTH = 8,
   parameter int   GAP_CYCLES  = 2,
   parameter logic FILL_BIT    = 1'b0
) (
   input  logic                              clock,
   input  logic                              sclr,
   input  logic                              tx_valid,
   input  logic [SHIFT_WIDTH-1:0]            tx_data,
   output logic                              tx_ready,
   input  logic                              abort,
   output logic                              sr_sclr,
   output logic                              sr_sset,
   output logic                              sr_load,
   output logic                              sr_enable,
   output logic                              sr_shiftin,
   output logic [SHIFT_WIDTH-1:0]            sr_data,
   input  logic                              sr_shiftout,
   output logic                              ser_out,
   output logic                              ser_valid,
   output logic                              busy,
   output logic                              done,
   output logic                              aborted,
   output logic [cnt_width(SHIFT_WIDTH)-1:0] bit_cnt
);

   localparam int BCW      = cnt_width(SHIFT_WIDTH);
   localparam int CNT_MAX  = (SHIFT_WIDTH > GAP_CYCLES) ? SHIFT_WIDTH : GAP_CYCLES;
   localparam int CNT_W    = cnt_width(CNT_MAX);
   localparam bit GAP_NONE = (GAP_CYCLES == 32'sd0);

   state_e                 state_q,   state_d;
   logic [SHIFT_WIDTH-1:0] hold_q,    hold_d;
   logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
   logic                   done_q,    done_d;
   logic                   aborted_q, aborted_d;

   logic                   cnt_load_s;
   logic [CNT_W-1:0]       cnt_load_val_s;
   logic                   cnt_dec_s;
   logic                   cnt_last_s;

   // One counter times both phases: loaded with SHIFT_WIDTH in LOAD, then
   // reloaded with GAP_CYCLES on the last shift.
   shift_frame_cnt #(
      .WIDTH (CNT_W)
   ) u_cnt (
      .clock    (clock),
      .sclr     (sclr),
      .load     (cnt_load_s),
      .load_val (cnt_load_val_s),
      .dec      (cnt_dec_s),
      .last     (cnt_last_s)
   );

   // Next-state, holding register, bit counter and pulse-flag logic.
   always_comb begin
      state_d        = state_q;
      hold_d         = hold_q;
      bit_cnt_d      = bit_cnt_q;
      done_d         = 1'b0;
      aborted_d      = 1'b0;
      cnt_load_s     = 1'b0;
      cnt_load_val_s = {CNT_W{1'b0}};
      cnt_dec_s      = 1'b0;
      case (state_q)
         CLR: begin
            state_d   = IDLE;
            bit_cnt_d = {BCW{1'b0}};
         end
         IDLE: begin
            if (tx_valid) begin
               hold_d  = tx_data;
               state_d = LOAD;
            end else begin
               state_d = IDLE;
            end
         end
         LOAD: begin
            bit_cnt_d      = {BCW{1'b0}};
            cnt_load_s     = 1'b1;
            cnt_load_val_s = CNT_W'(SHIFT_WIDTH);
            if (abort) begin
               state_d   = CLR;
               aborted_d = 1'b1;
            end else begin
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
            cnt_dec_s = 1'b1;
            // Abort beats frame completion on the final shift cycle.
            if (abort) begin
               state_d   = CLR;
               aborted_d = 1'b1;
            end else if (cnt_last_s) begin
               done_d         = 1'b1;
               cnt_load_s     = 1'b1;
               cnt_load_val_s = CNT_W'(GAP_CYCLES);
               if (GAP_NONE) begin
                  state_d = IDLE;
               end else begin
                  state_d = GAP;
               end
            end else begin
               state_d = SHIFT;
            end
         end
         GAP: begin
            cnt_dec_s = 1'b1;
            if (cnt_last_s) begin
               state_d = IDLE;
            end else begin
               state_d = GAP;
            end
         end
         default: begin
            state_d = CLR;
         end
      endcase
   end

   // State and data registers; reset suppresses any pending done/aborted.
   always_ff @(posedge clock) begin
      if (sclr) begin
         state_q   <= CLR;
         hold_q    <= {SHIFT_WIDTH{1'b0}};
         bit_cnt_q <= {BCW{1'b0}};
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         bit_cnt_q <= bit_cnt_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
      end
   end

   // Output decode from the registered state.
   always_comb begin
      tx_ready   = 1'b0;
      busy       = 1'b1;
      sr_sclr    = 1'b0;
      sr_load    = 1'b0;
      sr_enable  = 1'b0;
      sr_shiftin = 1'b0;
      ser_valid  = 1'b0;
      case (state_q)
         CLR: begin
            sr_sclr   = 1'b1;
            sr_enable = 1'b1;
         end
         IDLE: begin
            tx_ready = 1'b1;
            busy     = 1'b0;
         end
         LOAD: begin
            sr_load   = 1'b1;
            sr_enable = 1'b1;
         end
         SHIFT: begin
            sr_enable  = 1'b1;
            sr_shiftin = FILL_BIT;
            ser_valid  = 1'b1;
         end
         GAP: begin
            sr_enable = 1'b0;
         end
         default: begin
            busy = 1'b1;
         end
      endcase
   end

   assign sr_sset = 1'b0;
   assign sr_data = hold_q;
   assign ser_out = sr_shiftout;
   assign done    = done_q;
   assign aborted = aborted_q;
   assign bit_cnt = bit_cnt_q;

endmodule

// File: tb/tb_shift_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_frame_ctrl
// Directed bench for shift_frame_ctrl: instance a (GAP_CYCLES=2) and instance b
// (GAP_CYCLES=0), each driving a behavioural left-shifting register.
// Outputs are sampled on the falling edge; inputs change there too.
// -----------------------------------------------------------------------------
module tb_shift_frame_ctrl;

   localparam int W = 8;

   // Control vector order:
   // {tx_ready,busy,sr_sclr,sr_sset,sr_load,sr_enable,sr_shiftin,ser_valid,done,aborted}
   localparam logic [9:0] C_CLR       = 10'b0110010000;
   localparam logic [9:0] C_CLR_ABT   = 10'b0110010001;
   localparam logic [9:0] C_IDLE      = 10'b1000000000;
   localparam logic [9:0] C_IDLE_DONE = 10'b1000000010;
   localparam logic [9:0] C_LOAD      = 10'b0100110000;
   localparam logic [9:0] C_SHIFT     = 10'b0100010100;
   localparam logic [9:0] C_GAP       = 10'b0100000000;
   localparam logic [9:0] C_GAP_DONE  = 10'b0100000010;

   logic clock = 1'b0;
   logic sclr;
   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   logic         tx_valid_a, tx_ready_a, abort_a;
   logic [W-1:0] tx_data_a, sr_data_a, q_a;
   logic         sr_sclr_a, sr_sset_a, sr_load_a, sr_enable_a, sr_shiftin_a;
   logic         sr_shiftout_a, ser_out_a, ser_valid_a, busy_a, done_a, aborted_a;
   logic [3:0]   bit_cnt_a;

   logic         tx_valid_b, tx_ready_b, abort_b;
   logic [W-1:0] tx_data_b, sr_data_b, q_b;
   logic         sr_sclr_b, sr_sset_b, sr_load_b, sr_enable_b, sr_shiftin_b;
   logic         sr_shiftout_b, ser_out_b, ser_valid_b, busy_b, done_b, aborted_b;
   logic [3:0]   bit_cnt_b;

   shift_frame_ctrl #(.SHIFT_WIDTH(W), .GAP_CYCLES(2), .FILL_BIT(1'b0)) dut_a (
      .clock(clock), .sclr(sclr), .tx_valid(tx_valid_a), .tx_data(tx_data_a),
      .tx_ready(tx_ready_a), .abort(abort_a), .sr_sclr(sr_sclr_a), .sr_sset(sr_sset_a),
      .sr_load(sr_load_a), .sr_enable(sr_enable_a), .sr_shiftin(sr_shiftin_a),
      .sr_data(sr_data_a), .sr_shiftout(sr_shiftout_a), .ser_out(ser_out_a),
      .ser_valid(ser_valid_a), .busy(busy_a), .done(done_a), .aborted(aborted_a),
      .bit_cnt(bit_cnt_a));

   shift_frame_ctrl #(.SHIFT_WIDTH(W), .GAP_CYCLES(0), .FILL_BIT(1'b0)) dut_b (
      .clock(clock), .sclr(sclr), .tx_valid(tx_valid_b), .tx_data(tx_data_b),
      .tx_ready(tx_ready_b), .abort(abort_b), .sr_sclr(sr_sclr_b), .sr_sset(sr_sset_b),
      .sr_load(sr_load_b), .sr_enable(sr_enable_b), .sr_shiftin(sr_shiftin_b),
      .sr_data(sr_data_b), .sr_shiftout(sr_shiftout_b), .ser_out(ser_out_b),
      .ser_valid(ser_valid_b), .busy(busy_b), .done(done_b), .aborted(aborted_b),
      .bit_cnt(bit_cnt_b));

   // Left-shifting register models
   always @(posedge clock) begin
      if (sr_sclr_a)        q_a <= '0;
      else if (sr_sset_a)   q_a <= '1;
      else if (sr_enable_a) q_a <= sr_load_a ? sr_data_a : {q_a[W-2:0], sr_shiftin_a};
   end
   always @(posedge clock) begin
      if (sr_sclr_b)        q_b <= '0;
      else if (sr_sset_b)   q_b <= '1;
      else if (sr_enable_b) q_b <= sr_load_b ? sr_data_b : {q_b[W-2:0], sr_shiftin_b};
   end
   assign sr_shiftout_a = q_a[W-1];
   assign sr_shiftout_b = q_b[W-1];

   function automatic logic [9:0] ctl_a();
      return {tx_ready_a, busy_a, sr_sclr_a, sr_sset_a, sr_load_a, sr_enable_a,
              sr_shiftin_a, ser_valid_a, done_a, aborted_a};
   endfunction
   function automatic logic [9:0] ctl_b();
      return {tx_ready_b, busy_b, sr_sclr_b, sr_sset_b, sr_load_b, sr_enable_b,
              sr_shiftin_b, ser_valid_b, done_b, aborted_b};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clock);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [W-1:0] exp_bits;
      logic [24:1]  rdy, sv, so, dn, e_rdy, e_sv, e_so, e_dn;
      logic         done_seen;

      sclr = 1'b1;
      tx_valid_a = 1'b0; tx_data_a = '0; abort_a = 1'b0;
      tx_valid_b = 1'b0; tx_data_b = '0; abort_b = 1'b0;

      // Reset: two cycles of sclr, then release
      cyc(); cyc();
      chk("rst_ctl", ctl_a(), C_CLR);
      chk("rst_bit_cnt", bit_cnt_a, 0);
      chk("rst_sr_data", sr_data_a, 0);
      chk("rst_ser_out", ser_out_a, 0);
      sclr = 1'b0;
      cyc();
      chk("rst_idle_ctl", ctl_a(), C_IDLE);
      chk("rst_q", q_a, 0);
      chk("rst_idle_ctl_b", ctl_b(), C_IDLE);

      // Single frame 8'hA5
      tx_valid_a = 1'b1; tx_data_a = 8'hA5;
      cyc();
      tx_valid_a = 1'b0;
      chk("a5_load_ctl", ctl_a(), C_LOAD);
      chk("a5_load_data", sr_data_a, 8'hA5);
      exp_bits = 8'hA5;
      for (int i = 0; i < 8; i++) begin
         cyc();
         chk("a5_shift_ctl", ctl_a(), C_SHIFT);
         chk("a5_shift_bit", ser_out_a, exp_bits[7-i]);
         chk("a5_shift_cnt", bit_cnt_a, i);
      end
      cyc();
      chk("a5_gap_done", ctl_a(), C_GAP_DONE);
      chk("a5_final_cnt", bit_cnt_a, 8);
      cyc();
      chk("a5_gap2", ctl_a(), C_GAP);
      cyc();
      chk("a5_idle", ctl_a(), C_IDLE);

      // Back-to-back: 8'hFF then 8'h00 with tx_valid held
      tx_valid_a = 1'b1; tx_data_a = 8'hFF;
      for (int i = 1; i <= 24; i++) begin
         cyc();
         if (i == 1)  tx_data_a = 8'h00;
         if (i == 13) tx_valid_a = 1'b0;
         rdy[i] = tx_ready_a; sv[i] = ser_valid_a;
         so[i] = ser_out_a & ser_valid_a; dn[i] = done_a;
         e_rdy[i] = (i == 12) || (i == 24);
         e_sv[i]  = ((i >= 2) && (i <= 9)) || ((i >= 14) && (i <= 21));
         e_so[i]  = (i >= 2) && (i <= 9);
         e_dn[i]  = (i == 10) || (i == 22);
      end
      chk("b2b_ready", rdy, e_rdy);
      chk("b2b_ser_valid", sv, e_sv);
      chk("b2b_ser_out", so, e_so);
      chk("b2b_done", dn, e_dn);

      // Abort at bit_cnt=3
      tx_valid_a = 1'b1; tx_data_a = 8'h5A;
      cyc();
      tx_valid_a = 1'b0;
      repeat (4) cyc();
      chk("abt3_cnt", bit_cnt_a, 3);
      abort_a = 1'b1;
      cyc();
      abort_a = 1'b0;
      chk("abt3_clr", ctl_a(), C_CLR_ABT);
      cyc();
      chk("abt3_idle", ctl_a(), C_IDLE);
      chk("abt3_q_clr", q_a, 0);

      // Abort coincident with the 8th shift cycle
      tx_valid_a = 1'b1; tx_data_a = 8'hC3;
      cyc();
      tx_valid_a = 1'b0;
      repeat (8) cyc();
      chk("abt8_cnt", bit_cnt_a, 7);
      chk("abt8_shift", ctl_a(), C_SHIFT);
      abort_a = 1'b1;
      cyc();
      abort_a = 1'b0;
      chk("abt8_clr", ctl_a(), C_CLR_ABT);
      done_seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         done_seen = done_seen | done_a;
      end
      chk("abt8_no_done", done_seen, 0);
      chk("abt8_idle", ctl_a(), C_IDLE);

      // Abort in GAP and IDLE is ignored
      tx_valid_a = 1'b1; tx_data_a = 8'h81;
      cyc();
      tx_valid_a = 1'b0;
      repeat (9) cyc();
      chk("gapabt_done", ctl_a(), C_GAP_DONE);
      abort_a = 1'b1;
      cyc();
      chk("gapabt_gap", ctl_a(), C_GAP);
      cyc();
      chk("gapabt_idle", ctl_a(), C_IDLE);
      abort_a = 1'b0;

      // Reset in the middle of a frame
      tx_valid_a = 1'b1; tx_data_a = 8'h0F;
      cyc();
      tx_valid_a = 1'b0;
      repeat (3) cyc();
      chk("midrst_shift", ctl_a(), C_SHIFT);
      sclr = 1'b1;
      cyc();
      sclr = 1'b0;
      chk("midrst_clr", ctl_a(), C_CLR);
      chk("midrst_cnt", bit_cnt_a, 0);
      cyc();
      chk("midrst_idle", ctl_a(), C_IDLE);

      // GAP_CYCLES=0 instance: 8'h3C frame, next accept 10 cycles later
      exp_bits = 8'h3C;
      tx_valid_b = 1'b1; tx_data_b = 8'h3C;
      for (int i = 1; i <= 11; i++) begin
         cyc();
         rdy[i] = tx_ready_b; sv[i] = ser_valid_b;
         so[i] = ser_out_b & ser_valid_b; dn[i] = done_b;
         e_rdy[i] = (i == 10);
         e_dn[i]  = (i == 10);
         e_sv[i]  = (i >= 2) && (i <= 9);
         e_so[i]  = ((i >= 2) && (i <= 9)) ? exp_bits[9-i] : 1'b0;
         if (i == 10) chk("g0_idle_done", ctl_b(), C_IDLE_DONE);
         if (i == 11) begin
            chk("g0_reload", ctl_b(), C_LOAD);
            tx_valid_b = 1'b0;
         end
      end
      chk("g0_ready", rdy[11:1], e_rdy[11:1]);
      chk("g0_done", dn[11:1], e_dn[11:1]);
      chk("g0_ser_valid", sv[11:1], e_sv[11:1]);
      chk("g0_ser_out", so[11:1], e_so[11:1]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
